// File: rtl/traversal_stack.sv
// traversal_stack: multi-context LIFO for pending tree-node descriptors.
// One shared memory split into NUM_CTX fixed regions of DEPTH entries each.
// Every command and every status output refers to the context on ctx_sel.
module traversal_stack #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CTX    = 4,
  parameter int CTX_W      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CTX_W-1:0]      ctx_sel,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] top_data,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic [NUM_CTX-1:0]    overflow,
  output logic [NUM_CTX-1:0]    underflow
);

  localparam int MEM_N  = NUM_CTX * DEPTH;
  localparam int ADDR_W = (MEM_N > 1) ? $clog2(MEM_N) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_N];
  logic [CNT_W-1:0]      cnt [NUM_CTX];

  logic [NUM_CTX-1:0] sel_hit;
  logic               ctx_ok;
  logic [CNT_W-1:0]   sel_cnt;
  logic [ADDR_W-1:0]  sel_base;
  logic [ADDR_W-1:0]  top_addr;
  logic [ADDR_W-1:0]  push_addr;
  logic               is_empty;
  logic               is_full;

  logic [CNT_W-1:0]   cnt_new;
  logic               set_ovf;
  logic               set_udf;
  logic               clr_err;
  logic               mem_we;
  logic               rd_en;
  logic [ADDR_W-1:0]  wr_addr;

  // Select the addressed context; an out-of-range ctx_sel hits nothing and reads as empty.
  always_comb begin
    sel_hit  = '0;
    sel_cnt  = '0;
    sel_base = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      if (ctx_sel == CTX_W'(c)) begin
        sel_hit[c] = 1'b1;
        sel_cnt    = cnt[c];
        sel_base   = ADDR_W'(c * DEPTH);
      end else begin
        sel_hit[c] = 1'b0;
      end
    end
  end

  assign ctx_ok    = |sel_hit;
  assign is_empty  = (sel_cnt == CNT_W'(0));
  assign is_full   = (sel_cnt == CNT_W'(DEPTH));
  assign top_addr  = sel_base + ADDR_W'(sel_cnt) - ADDR_W'(1'b1);
  assign push_addr = sel_base + ADDR_W'(sel_cnt);

  assign count    = sel_cnt;
  assign full     = is_full;
  assign empty    = is_empty;
  assign top_data = (ctx_ok && !is_empty) ? mem[top_addr] : '0;

  // Decode the command on the selected context: flush wins, then push/pop combinations.
  always_comb begin
    cnt_new = sel_cnt;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    clr_err = 1'b0;
    mem_we  = 1'b0;
    rd_en   = 1'b0;
    wr_addr = push_addr;
    if (reset || !ctx_ok) begin
      cnt_new = sel_cnt;
    end else if (flush) begin
      cnt_new = '0;
      clr_err = 1'b1;
    end else if (push && pop) begin
      if (!is_empty) begin
        // Replace: hand out the old top and overwrite it in place.
        rd_en   = 1'b1;
        mem_we  = 1'b1;
        wr_addr = top_addr;
      end else begin
        // Nothing to pop: the push still lands, the pop is flagged.
        mem_we  = 1'b1;
        wr_addr = push_addr;
        cnt_new = sel_cnt + CNT_W'(1);
        set_udf = 1'b1;
      end
    end else if (push) begin
      if (is_full) begin
        set_ovf = 1'b1;
      end else begin
        mem_we  = 1'b1;
        cnt_new = sel_cnt + CNT_W'(1);
      end
    end else if (pop) begin
      if (is_empty) begin
        set_udf = 1'b1;
      end else begin
        rd_en   = 1'b1;
        cnt_new = sel_cnt - CNT_W'(1);
      end
    end else begin
      cnt_new = sel_cnt;
    end
  end

  // Shared entry storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Per-context occupancy, sticky error flags and the registered pop result.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CTX; c++) begin
        cnt[c] <= '0;
      end
      overflow  <= '0;
      underflow <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CTX; c++) begin
        if (sel_hit[c]) begin
          cnt[c] <= cnt_new;
          if (clr_err) begin
            overflow[c]  <= 1'b0;
            underflow[c] <= 1'b0;
          end else begin
            if (set_ovf) begin
              overflow[c] <= 1'b1;
            end
            if (set_udf) begin
              underflow[c] <= 1'b1;
            end
          end
        end
      end
      out_valid <= rd_en;
      if (rd_en) begin
        data_out <= mem[top_addr];
      end
    end
  end

endmodule

// File: doc/traversal_stack.md
# traversal_stack

Multi-context LIFO holding pending tree-node descriptors for the packet-classification traversal engine, one independent stack per in-flight lookup context. The engines push child pointers and pop the next node to visit. All contexts share one memory, partitioned into fixed regions. It adds the following:
- Per-context pointers and occupancy counts.
- Push and pop in the same cycle, which replaces the top entry.
- A peek port.
- Per-context flush.
- Sticky overflow and underflow error flags.

## Interface
- DEPTH, 64, entries per context (≥2)
- DATA_WIDTH, 32, bits per entry
- NUM_CTX, 4, number of independent stacks (≥1)
- CTX_W, max(1,$clog2(NUM_CTX)), context select width (derived)
- CNT_W, $clog2(DEPTH+1), occupancy width (derived)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- ctx_sel  in  CTX_W  context addressed by push/pop/flush and by all status outputs
- push  in  1  write data_in onto ctx_sel stack
- pop  in  1  remove top of ctx_sel stack
- flush  in  1  empty ctx_sel stack and clear its error bits
- data_in  in  DATA_WIDTH  push payload
- data_out  out  DATA_WIDTH  popped entry, registered
- out_valid  out  1  one-cycle pulse: data_out holds a popped entry
- top_data  out  DATA_WIDTH  combinational peek of ctx_sel top; 0 when empty
- count  out  CNT_W  occupancy of ctx_sel
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  NUM_CTX  sticky, bit c: push refused on context c
- underflow  out  NUM_CTX  sticky, bit c: pop refused on context c

## Operation
- Memory is NUM_CTX×DEPTH entries. Context c owns addresses c·DEPTH … c·DEPTH+DEPTH−1. Memory contents are not reset.
- Per-context pointer cnt[c] counts occupied entries. The top entry is at c·DEPTH+cnt[c]−1.
- Command priority, all acting on ctx_sel: flush > push/pop combination.
- flush: cnt=0, overflow[c]=0, underflow[c]=0. push and pop are ignored that cycle. out_valid=0.
- push only, not full: mem[base+cnt] ← data_in, then cnt+1.
- push only, full: no write, cnt unchanged, overflow[c] ← 1.
- pop only, not empty: data_out ← top, out_valid=1 next cycle, then cnt−1.
- pop only, empty: out_valid=0, data_out holds, underflow[c] ← 1.
- push and pop, not empty (including full): replace. data_out ← old top, out_valid=1, mem[top] ← data_in, cnt unchanged. No flag is set.
- push and pop, empty: the push executes (cnt→1), the pop is refused, and underflow[c] ← 1.
- ctx_sel ≥ NUM_CTX: all commands are ignored with no state change. Status outputs read count=0, empty=1, full=0, top_data=0.
- Contexts not selected are untouched.
- Reset: every cnt=0, data_out=0, out_valid=0, overflow=0, underflow=0.

## Timing
- Write and pointer updates take effect at the clock edge where the command is sampled.
- count, full, empty, and top_data reflect the new state in the following cycle. They are combinational on ctx_sel, so they track context switches within the same cycle.
- Pop latency: 1 cycle. data_out and out_valid are registered. out_valid is low in every cycle without a successful pop.
- Back-to-back pops on one context: each returns the successive next-lower entry, one per cycle.
- Push at cycle N, pop at cycle N+1: returns the cycle-N data at N+2.
- Replace at cycle N followed by pop at cycle N+1: the pop returns the data written at N.
- Throughput: one command per cycle, with no stalls.
- Reset asserted mid-operation discards all contents in one cycle. out_valid is 0 in the cycle after reset, even if pop was high during reset.
- Error bits stay set until reset or a flush of that context.

## Test plan
- Reset, then on ctx 0 push 0xA1, 0xA2, 0xA3, then pop ×3.
  - Required: data_out 0xA3, 0xA2, 0xA1, each with out_valid=1 one cycle after its pop.
  - Required: count 3→0 and empty=1.
- Interleaving contexts: push 0x10 on ctx 1, push 0x20 on ctx 2, push 0x11 on ctx 1, then pop ctx 2 and pop ctx 1.
  - Required: pops return 0x20 and 0x11.
  - Required: count reads ctx1=1 and ctx2=0 afterwards.
- Fill ctx 3 with DEPTH pushes, then push 0xFF.
  - Required: full=1 and overflow[3]=1.
  - Required: top_data is unchanged, and DEPTH pops return the original values in reverse.
- Pop on empty ctx 0.
  - Required: out_valid=0 and underflow[0]=1.
  - Then flush ctx 0. Required: underflow[0]=0.
- Replace: ctx 0 holds 0x5, 0x6. Assert push+pop with 0x7.
  - Required: data_out=0x6 with out_valid=1, count stays 2, top_data=0x7.
  - Then push+pop on full ctx. Required: no overflow.
- Push 0x1 and 0x2 on ctx 2, then assert reset together with a pop.
  - Required: the next cycle has out_valid=0, all counts 0, and all flags 0.
  - Then pop ctx 2. Required: underflow[2]=1.
